imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//   Shares the single-port, synchronous-read instruction memory between two requesters:
//   the core fetch stage and the program loader/debug port.
//   - Issues at most one memory access per cycle.
//   - Routes each read response back to its requester.
//   - Provides a loader lock for safe in-system reprogramming, and starvation protection for fetch.
//   Sits between the fetch stage and the instruction memory macro.
// PARAMETERS
//   ADDR_W      8   word-index width of the memory (256 words); byte address bits [ADDR_W+1:2] are used
//   STARVE_MAX  4   consecutive loader wins, while fetch waits, before fetch is forced a grant (>=1)
// PORTS
//   clk          in   1       clock, all state on posedge
//   rst_n        in   1       asynchronous, active-low reset
//   f_req        in   1       fetch request
//   f_addr       in   32      fetch byte address
//   f_flush      in   1       kill the fetch response due this cycle (redirect)
//   f_gnt        out  1       fetch request accepted this cycle
//   f_rvalid     out  1       fetch read data valid
//   f_rdata      out  32      fetch read data
//   l_req        in   1       loader request
//   l_we         in   1       loader write (1) / read (0)
//   l_addr       in   32      loader byte address
//   l_wdata      in   32      loader write data
//   l_lock       in   1       loader exclusive-access request
//   l_gnt        out  1       loader request accepted this cycle
//   l_rvalid     out  1       loader response (read data or write ack)
//   l_rdata      out  32      loader read data (don't-care on write ack)
//   m_en         out  1       memory access enable
//   m_we         out  1       memory write enable
//   m_addr       out  ADDR_W  memory word index
//   m_wdata      out  32      memory write data
//   m_rdata      in   32      memory read data, valid the cycle after m_en
//   err_misalign out  1       misaligned-access pulse (tied 0 without the macro)
// BEHAVIOUR
//   Grants are combinational, in the same cycle as the request.
//   - m_en = f_gnt | l_gnt; m_we = l_gnt & l_we.
//   - m_addr = granted addr[ADDR_W+1:2]. Upper address bits are ignored (wrap).
//   Responses arrive exactly 1 cycle after the grant.
//   - Registered owner flags f_pend / l_pend.
//   - f_rvalid = f_pend & ~f_flush; l_rvalid = l_pend.
//   - rdata = m_rdata.
//   - A grant may be issued every cycle (fully pipelined); there is no back-pressure on responses.
//   Arbitration in S_RUN when both requesters are active:
//   - The loader wins unless starve_cnt == STARVE_MAX; then fetch wins and starve_cnt clears.
//   - starve_cnt increments (saturating) when f_req=1 and the loader is granted.
//   - starve_cnt clears when fetch is granted or f_req=0.
//   FSM (2-bit state):
//   - S_RUN -> S_LOCKED on l_lock=1. f_gnt is masked combinationally by l_lock in the same cycle.
//   - S_LOCKED: only the loader is granted; starve_cnt is held at 0.
//   - S_LOCKED -> S_DRAIN on l_lock=0.
//   - S_DRAIN: no grants for 1 cycle, so the last write is committed before any fetch.
//   - S_DRAIN -> S_RUN unconditionally.
//   Flush: f_flush at cycle t suppresses only the response of the fetch granted at t-1.
//   A fetch granted at t still responds at t+1.
//   Reset (asserted at any time):
//   - Clears f_pend, l_pend and starve_cnt; state = S_RUN.
//   - All outputs go to 0 immediately. An in-flight response is dropped and never reissued.
//   An unrequested side never sees gnt or rvalid.
// CONFIGURATION
//   Macro IMEM_MISALIGN_CHECK_EN.
//   - Defined: a request with addr[1:0]!=0 is granted (consumed) but m_en stays 0 and no write occurs.
//     The next cycle brings that side's rvalid with rdata=0 and err_misalign=1 for 1 cycle.
//     This response is still subject to f_flush.
//   - Undefined: addr[1:0] are ignored and err_misalign is constant 0.
// STRUCTURE
//   Shared package riscv_structures:
//   - typedef enum logic [1:0] imem_arb_state_e {S_RUN, S_LOCKED, S_DRAIN}
//   - localparam IMEM_ADDR_W = 8
//   - struct imem_req_t {addr, wdata, we}
//   Sub-module imem_arb_pick (combinational): takes f_req, l_req, lock/drain and starve_cnt==MAX;
//   returns f_gnt and l_gnt. The top level holds the FSM, counter, pending flags and muxes.
// TESTING
//   1. Fetch only: f_req, f_addr=0x08 -> f_gnt same cycle, m_addr=2, next cycle f_rvalid=1 with
//      f_rdata=mem[2].
//   2. Contention, STARVE_MAX=4, both requesting continuously -> grant pattern L,L,L,L,F,L,L,L,L,F.
//   3. Lock: l_lock=1, write 0xDEADBEEF to 0x10, l_lock=0 while f_req=1 -> f_gnt=0 through the
//      S_DRAIN cycle; the next fetch of 0x10 returns 0xDEADBEEF.
//   4. Flush: fetch granted at t, f_flush=1 at t+1 -> f_rvalid=0 at t+1; a fetch granted at t+1 has
//      f_rvalid=1 at t+2.
//   5. Reset mid-operation: rst_n=0 while l_pend=1 -> l_rvalid=0 immediately; after release,
//      state=S_RUN and starve_cnt=0.
//   6. Misalign with the macro, f_addr=0x06 -> m_en=0, next cycle f_rvalid=1, f_rdata=0,
//      err_misalign=1. Without the macro -> m_addr=1 and err_misalign=0.

Source files
------------

// File: rtl/riscv_structures.sv
// Shared types for the instruction-memory arbiter: FSM states, the default
// memory index width, the request bundle used by the address/data mux, and
// an alignment helper.
package riscv_structures;

    localparam int IMEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_LOCKED = 2'b01,
        S_DRAIN  = 2'b10
    } imem_arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } imem_req_t;

    // A word access is misaligned when either of the two byte-offset bits is set.
    function automatic logic addr_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational grant picker for the instruction-memory arbiter.
// Drain blocks everyone, lock gives the bus to the loader only, and under
// contention the loader wins unless fetch has been starved to the limit.
module imem_arb_pick (
    input  logic f_req,
    input  logic l_req,
    input  logic lock,
    input  logic drain,
    input  logic starved,
    output logic f_gnt,
    output logic l_gnt
);

    // Grant selection; at most one of the two grants is ever set.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (drain) begin
            f_gnt = 1'b0;
            l_gnt = 1'b0;
        end else if (lock) begin
            f_gnt = 1'b0;
            l_gnt = l_req;
        end else if (f_req && l_req) begin
            if (starved) begin
                f_gnt = 1'b1;
            end else begin
                l_gnt = 1'b1;
            end
        end else begin
            f_gnt = f_req;
            l_gnt = l_req;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter between the fetch stage and the loader/debug port.
// Same-cycle grants, responses exactly one cycle later, loader lock with a
// one-cycle drain, and a starvation limit for fetch.
// Optional build macro IMEM_MISALIGN_CHECK_EN: misaligned requests are consumed
// without touching memory and answered with rdata=0 plus an err_misalign pulse.
module imem_arbiter
    import riscv_structures::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              err_misalign
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    imem_arb_state_e  state_r, state_nxt_s;
    logic [CNT_W-1:0] starve_cnt_r, starve_nxt_s;
    logic             f_pend_r, l_pend_r, f_mis_r, l_mis_r;
    logic             f_gnt_s, l_gnt_s, f_mis_s, l_mis_s;
    logic             lock_s, drain_s, starved_s;
    imem_req_t        f_pkt_s, l_pkt_s, sel_pkt_s;

`ifdef IMEM_MISALIGN_CHECK_EN
    assign f_mis_s = addr_misaligned(f_addr);
    assign l_mis_s = addr_misaligned(l_addr);
`else
    assign f_mis_s = 1'b0;
    assign l_mis_s = 1'b0;
`endif

    // A lock request already masks fetch in the cycle it is raised.
    assign lock_s    = (state_r == S_LOCKED) || ((state_r == S_RUN) && l_lock);
    assign drain_s   = (state_r == S_DRAIN);
    assign starved_s = (starve_cnt_r == CNT_MAX);

    imem_arb_pick u_pick (
        .f_req   (f_req),
        .l_req   (l_req),
        .lock    (lock_s),
        .drain   (drain_s),
        .starved (starved_s),
        .f_gnt   (f_gnt_s),
        .l_gnt   (l_gnt_s)
    );

    assign f_pkt_s = '{addr: f_addr, wdata: 32'h0000_0000, we: 1'b0};
    assign l_pkt_s = '{addr: l_addr, wdata: l_wdata,       we: l_we};

    // Only the granted side's byte-address bits [ADDR_W+1:2] reach the memory.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{sel_pkt_s.addr[31:ADDR_W+2], sel_pkt_s.addr[1:0]};

    // Select the request bundle of whichever side holds the grant.
    always_comb begin
        if (l_gnt_s) begin
            sel_pkt_s = l_pkt_s;
        end else begin
            sel_pkt_s = f_pkt_s;
        end
    end

    // Memory port drive; everything is quiet while reset is asserted.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = {ADDR_W{1'b0}};
        m_wdata = 32'h0000_0000;
        if (!rst_n) begin
            m_en = 1'b0;
        end else begin
            m_en = (f_gnt_s && !f_mis_s) || (l_gnt_s && !l_mis_s);
            m_we = l_gnt_s && sel_pkt_s.we && !l_mis_s;
            if (m_en) begin
                m_addr = sel_pkt_s.addr[ADDR_W+1:2];
            end else begin
                m_addr = {ADDR_W{1'b0}};
            end
            if (m_we) begin
                m_wdata = sel_pkt_s.wdata;
            end else begin
                m_wdata = 32'h0000_0000;
            end
        end
    end

    assign f_gnt    = rst_n && f_gnt_s;
    assign l_gnt    = rst_n && l_gnt_s;
    assign f_rvalid = f_pend_r && !f_flush;
    assign l_rvalid = l_pend_r;
    assign f_rdata  = (rst_n && !f_mis_r) ? m_rdata : 32'h0000_0000;
    assign l_rdata  = (rst_n && !l_mis_r) ? m_rdata : 32'h0000_0000;

`ifdef IMEM_MISALIGN_CHECK_EN
    assign err_misalign = (f_rvalid && f_mis_r) || (l_rvalid && l_mis_r);
`else
    assign err_misalign = 1'b0;
`endif

    // Lock / drain sequencing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_RUN:    state_nxt_s = l_lock ? S_LOCKED : S_RUN;
            S_LOCKED: state_nxt_s = l_lock ? S_LOCKED : S_DRAIN;
            S_DRAIN:  state_nxt_s = S_RUN;
            default:  state_nxt_s = S_RUN;
        endcase
    end

    // Starvation count: consecutive loader wins while fetch keeps asking.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if ((state_r != S_RUN) || l_lock) begin
            starve_nxt_s = {CNT_W{1'b0}};
        end else if (f_gnt_s || !f_req) begin
            starve_nxt_s = {CNT_W{1'b0}};
        end else if (l_gnt_s && !starved_s) begin
            starve_nxt_s = starve_cnt_r + CNT_ONE;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_nxt_s;
        end
    end

    // Response ownership: who was granted last cycle, and whether it was misaligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pend_r <= 1'b0;
            l_pend_r <= 1'b0;
            f_mis_r  <= 1'b0;
            l_mis_r  <= 1'b0;
        end else begin
            f_pend_r <= f_gnt_s;
            l_pend_r <= l_gnt_s;
            f_mis_r  <= f_gnt_s && f_mis_s;
            l_mis_r  <= l_gnt_s && l_mis_s;
        end
    end

endmodule
